alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle unsigned multiplier sequencer that time-shares the single-cycle processor's existing 32-bit ALU. It computes the low 32 bits of a 32×32 product by shift-and-add, issuing one ALU ADD per cycle. While `busy` is high it owns the ALU's operand and control inputs. The enclosing datapath muxes the ALU inputs between this block and the main decoder, using `busy` as the select.

## Interface
Parameters:
- `WIDTH`, default 32: operand, product and ALU width. The iteration count equals `WIDTH`.
- `ALU_ADD`, default 4'b0010: ALU control code for addition.
- `ALU_NOP`, default 4'b1111: unsupported ALU code. The ALU returns 0 for this code; the block drives it when idle.

Ports:
- `clk`, input, 1: the single clock.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `start`, input, 1: request a multiply. Sampled only in IDLE.
- `op_a`, input, WIDTH: multiplicand. Latched on an accepted `start`.
- `op_b`, input, WIDTH: multiplier. Latched on an accepted `start`.
- `busy`, output, 1: high in RUN and DONE. ALU mux select.
- `done`, output, 1: one-cycle pulse. `product` is valid when it is high.
- `product`, output, WIDTH: result, mod 2^WIDTH. Held until the next result.
- `alu_ctrl`, output, 4: ALU control to the shared ALU.
- `alu_in1`, output, WIDTH: ALU operand 1 (accumulator).
- `alu_in2`, output, WIDTH: ALU operand 2 (gated multiplicand).
- `alu_result`, input, WIDTH: combinational result from the shared ALU.

## Operation
- Internal registers:
  - `mcand` (WIDTH): shifted multiplicand.
  - `mplier` (WIDTH): shifted multiplier.
  - `acc` (WIDTH): accumulator.
  - `count` (log2(WIDTH)+1 bits).
- States: IDLE, RUN, DONE.
- IDLE:
  - Drives `alu_ctrl`=ALU_NOP, `alu_in1`=0, `alu_in2`=0.
  - On `start`=1: `mcand`<=op_a, `mplier`<=op_b, `acc`<=0, `count`<=0, go to RUN.
- RUN, every cycle:
  - Drives `alu_ctrl`=ALU_ADD, `alu_in1`=acc, `alu_in2`= mplier[0] ? mcand : 0.
  - Updates: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - When count==WIDTH-1, this is the last add: go to DONE.
- DONE:
  - `done`=1 for exactly one cycle; `product`<=acc on entry.
  - ALU outputs return to idle values; go to IDLE.
- Arithmetic: all adds wrap modulo 2^WIDTH. The ALU's zero/carry flag is ignored; the upper product half is discarded.
- `start` while `busy`=1 is ignored and is not queued.
- `op_a`/`op_b` changes after acceptance have no effect.

## Timing
- Reset values (asynchronous on `rst_n`=0): state=IDLE; busy=0, done=0, product=0; alu_ctrl=ALU_NOP, alu_in1=0, alu_in2=0; internal registers 0.
- Reset mid-operation aborts immediately. `product` returns to 0 and no `done` is emitted.
- Latency without early exit: `start` sampled at edge 0; RUN spans cycles 1..WIDTH; `done` is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- `busy` rises the cycle after `start` is accepted and falls after the `done` cycle.
- Back-to-back throughput is one multiply per WIDTH+2 cycles. A `start` held high through DONE is accepted in the following IDLE cycle.
- `alu_result` is used combinationally within the same cycle. The ALU must settle within one period.

## Configuration
- Macro `ALU_MUL_EARLY_EXIT_EN`.
- Defined:
  - In RUN, if `mplier`==0 at the start of a cycle, go straight to DONE. No ALU op is issued and `acc` is not updated.
  - `done` arrives in cycle 2 + (index of the highest set bit of op_b + 1).
  - op_b=0 gives `done` in cycle 2.
  - The count limit still applies, so op_b[WIDTH-1]=1 gives cycle WIDTH+1.
- Undefined: fixed WIDTH iterations, as above. Results are identical in both builds; only latency differs.

## Test plan
- Reset, then op_a=3, op_b=7, `start` pulse → `done` in cycle 33 (cycle 5 with macro), product=0x00000015, busy=1 in cycles 1..33.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → product=0x00000001, `done` in cycle 33 in both builds.
- op_a=0x12345678, op_b=0 → product=0. `done` in cycle 33 without macro, cycle 2 with macro. alu_ctrl=ALU_NOP outside RUN.
- `start` with op_a=2, op_b=3, then `start` with op_a=9, op_b=9 pulsed at cycle 10 → second request ignored; product=6, single `done` pulse.
- Assert rst_n=0 at cycle 15 of a run → outputs at reset values asynchronously, no `done`. Then 5×6 completes with product=30.
- `start` held high continuously with op_a=4, op_b=4 → product=16, `done` pulses every 34 cycles without macro.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// +--------------------------------------------------------------------------+
// | alu_mul_sequencer                                                        |
// | Shift-and-add multiplier (low WIDTH product bits) that borrows the       |
// | shared ALU for one ADD per cycle while busy. Optional early exit on a    |
// | drained multiplier: define ALU_MUL_EARLY_EXIT_EN.                        |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_NOP = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int                CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_product;
  logic             w_issue;
  logic [WIDTH-1:0] w_acc_next;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    alu_ctrl     = ALU_NOP;
    alu_in1      = '0;
    alu_in2      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
`ifdef ALU_MUL_EARLY_EXIT_EN
        // Nothing left to add once the multiplier has drained.
        if (r_mplier == '0) begin
          w_state_next = S_DONE;
        end else begin
          w_issue = 1'b1;
          if (r_count == C_LAST) w_state_next = S_DONE;
        end
`else
        w_issue = 1'b1;
        if (r_count == C_LAST) w_state_next = S_DONE;
`endif
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (w_issue) begin
      alu_ctrl = ALU_ADD;
      alu_in1  = r_acc;
      alu_in2  = r_mplier[0] ? r_mcand : '0;
    end
  end

  // The accumulator value that DONE will present, including the final add.
  assign w_acc_next = w_issue ? alu_result : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_mcand  <= op_a;
        r_mplier <= op_b;
        r_acc    <= '0;
        r_count  <= '0;
      end else if (w_issue) begin
        r_acc    <= alu_result;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + 1'b1;
      end
      if (r_state == S_RUN && w_state_next == S_DONE) r_product <= w_acc_next;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_alu_mul_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_alu_mul_sequencer                                                     |
// | Directed self-checking bench with a behavioural shared ALU.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_mul_sequencer;

`ifdef ALU_MUL_EARLY_EXIT_EN
  localparam bit C_EE = 1'b1;
`else
  localparam bit C_EE = 1'b0;
`endif

  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_NOP = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_result;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  // Shared ALU: ADD adds, the unsupported code returns zero.
  assign alu_result = (alu_ctrl == C_ADD) ? alu_in1 + alu_in2 : 32'd0;

  alu_mul_sequencer #(.WIDTH(32), .ALU_ADD(C_ADD), .ALU_NOP(C_NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .alu_ctrl   (alu_ctrl),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_result (alu_result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    else n_pass++;
  endtask

  // Called #1 after a rising edge; cycle c is sampled #1 after edge c-1.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_prod, input int exp_lat, input int poke);
    int first   = 0;
    int n_done  = 0;
    bit busy_ok = 1'b1;
    check({tag, ".idle_ctrl"}, 32'(alu_ctrl), 32'(C_NOP));
    check({tag, ".idle_in1"}, alu_in1, 32'd0);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        n_done++;
        if (first == 0) begin
          first = c;
          check({tag, ".product"}, product, exp_prod);
          check({tag, ".done_ctrl"}, 32'(alu_ctrl), 32'(C_NOP));
        end
      end
      if (first == 0 && !busy) busy_ok = 1'b0;
      if (first != 0 && c == first + 1) check({tag, ".busy_fall"}, 32'(busy), 32'd0);
      if (poke != 0 && c == poke) begin
        start = 1'b1;
        op_a  = 32'd9;
        op_b  = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check({tag, ".latency"}, 32'(first), 32'(exp_lat));
    check({tag, ".n_done"}, 32'(n_done), 32'd1);
    check({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int first;
    int prev;
    int n_pulse;
    int n_bad_period;
    int n_done_rst;

    #2;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.product", product, 32'd0);
    check("rst.alu_ctrl", 32'(alu_ctrl), 32'(C_NOP));
    check("rst.alu_in2", alu_in2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_mul("mul3x7", 32'd3, 32'd7, 32'h15, C_EE ? 5 : 33, 0);
    run_mul("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, 0);
    run_mul("mulzero", 32'h1234_5678, 32'd0, 32'd0, C_EE ? 2 : 33, 0);
    run_mul("ignore", 32'd2, 32'd3, 32'd6, C_EE ? 4 : 33, C_EE ? 2 : 10);

    // Abort a run part-way with an asynchronous reset.
    op_a  = 32'h11;
    op_b  = 32'h8000_0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("abort.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.product", product, 32'd0);
    check("abort.alu_ctrl", 32'(alu_ctrl), 32'(C_NOP));
    check("abort.alu_in1", alu_in1, 32'd0);
    n_done_rst = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done_rst++;
      if (c == 3) rst_n = 1'b1;
    end
    check("abort.no_done", 32'(n_done_rst), 32'd0);
    run_mul("mul5x6", 32'd5, 32'd6, 32'd30, C_EE ? 5 : 33, 0);

    // Held start: one multiply per latency+1 cycles.
    op_a         = 32'd4;
    op_b         = 32'd4;
    start        = 1'b1;
    first        = 0;
    prev         = 0;
    n_pulse      = 0;
    n_bad_period = 0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 110; c++) begin
      if (done) begin
        n_pulse++;
        if (first == 0) begin
          first = c;
          check("held.product", product, 32'd16);
        end else if (c - prev != (C_EE ? 6 : 34)) begin
          n_bad_period++;
        end
        prev = c;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("held.first", 32'(first), C_EE ? 32'd5 : 32'd33);
    check("held.pulses", 32'(n_pulse), C_EE ? 32'd18 : 32'd3);
    check("held.period", 32'(n_bad_period), 32'd0);
    check("held.product_end", product, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
